// File: rtl/addsub15_pkg.sv
// Shared constants and types for the 15-bit add/sub arbiter.
// Optional feature macro: ADDSUB15_ARB_SAT_EN (saturating result on overflow).
package addsub15_pkg;
   localparam int WIDTH = 15;
   localparam int CNT_W = 4;   // enough for SETTLE_CYC up to 15

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [WIDTH-1:0] SAT_MAX = 15'h3FFF;
   localparam logic [WIDTH-1:0] SAT_MIN = 15'h4000;
endpackage

// File: rtl/addsub15_arbiter_if.sv
// Bus bundle for addsub15_arbiter: requester handshake, response and
// the operand/result wires of the shared adder/subtractor datapath.
interface addsub15_arbiter_if;
   import addsub15_pkg::*;

   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic [1:0]         req_sub;
   logic [1:0]         rsp_valid;
   logic [1:0]         rsp_ready;
   logic [WIDTH-1:0]   rsp_s;
   logic               rsp_v;
   logic [WIDTH-1:0]   dp_a;
   logic [WIDTH-1:0]   dp_b;
   logic               dp_c0;
   logic [WIDTH-1:0]   dp_s;
   logic               dp_v;
   logic               busy;

   // Arbiter side
   modport slave (
      input  req_valid, req_a, req_b, req_sub, rsp_ready, dp_s, dp_v,
      output req_ready, rsp_valid, rsp_s, rsp_v, dp_a, dp_b, dp_c0, busy
   );

   // Environment side (requesters + datapath)
   modport master (
      output req_valid, req_a, req_b, req_sub, rsp_ready, dp_s, dp_v,
      input  req_ready, rsp_valid, rsp_s, rsp_v, dp_a, dp_b, dp_c0, busy
   );
endinterface

// File: rtl/addsub15_arbiter_rr_arb2.sv
// Two-input round-robin picker. The pointer names the requester with
// priority; after every grant it moves to the requester that lost.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output logic       o_win,
   output logic       o_upd
);
   logic r_ptr;

   // Winner: pointer requester if valid, otherwise the other one.
   always_comb begin
      o_win = i_req[r_ptr] ? r_ptr : ~r_ptr;
      o_upd = i_en & (|i_req);
      o_gnt = 2'b00;
      if (o_upd) o_gnt = o_win ? 2'b10 : 2'b01;
   end

   // Pointer flips to the non-winner on each grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_ptr <= 1'b0;
      else if (o_upd) r_ptr <= ~o_win;
   end
endmodule

// File: rtl/addsub15_arbiter.sv
// Shares one external 15-bit ripple adder/subtractor between two requesters.
// Grants round-robin, holds operands for SETTLE_CYC cycles, captures the
// sum/overflow and returns it over a valid/ready handshake.
// Optional feature macro: ADDSUB15_ARB_SAT_EN (saturate rsp_s on overflow).
module addsub15_arbiter
   import addsub15_pkg::*;
#(
   parameter int SETTLE_CYC = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   addsub15_arbiter_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t           r_state, w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_gidx;
   logic [WIDTH-1:0] r_dp_a, r_dp_b, r_rsp_s;
   logic             r_dp_c0, r_rsp_v;
   logic [1:0]       w_gnt;
   logic             w_win, w_upd, w_en;
   logic [WIDTH-1:0] w_sel_a, w_sel_b, w_cap_s;
   logic             w_sel_sub;

   // No grant is advertised outside IDLE or while reset is held.
   assign w_en = (r_state == IDLE) & rst_n;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_req (bus.req_valid),
      .o_gnt (w_gnt),
      .o_win (w_win),
      .o_upd (w_upd)
   );

   assign w_sel_a   = w_win ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
   assign w_sel_b   = w_win ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
   assign w_sel_sub = bus.req_sub[w_win];

`ifdef ADDSUB15_ARB_SAT_EN
   // Sign of the wrapped sum is inverted on overflow: set MSB means positive overflow.
   assign w_cap_s = bus.dp_v ? (bus.dp_s[WIDTH-1] ? SAT_MAX : SAT_MIN) : bus.dp_s;
`else
   assign w_cap_s = bus.dp_s;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (w_upd) w_nxt = EXEC;
         EXEC:    if (r_cnt == '0) w_nxt = RESP;
         RESP:    if (bus.rsp_ready[r_gidx]) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   // Operand latch on grant, settle countdown, result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_gidx  <= 1'b0;
         r_dp_a  <= '0;
         r_dp_b  <= '0;
         r_dp_c0 <= 1'b0;
         r_rsp_s <= '0;
         r_rsp_v <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_upd) begin
               r_dp_a  <= w_sel_a;
               r_dp_b  <= w_sel_b;
               r_dp_c0 <= w_sel_sub;
               r_gidx  <= w_win;
               r_cnt   <= CNT_LOAD;
            end
            EXEC: if (r_cnt == '0) begin
               r_rsp_s <= w_cap_s;
               r_rsp_v <= bus.dp_v;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = w_gnt;
   assign bus.rsp_valid = (r_state == RESP) ? (r_gidx ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_s     = r_rsp_s;
   assign bus.rsp_v     = r_rsp_v;
   assign bus.dp_a      = r_dp_a;
   assign bus.dp_b      = r_dp_b;
   assign bus.dp_c0     = r_dp_c0;
   assign bus.busy      = (r_state != IDLE);
endmodule

// File: doc/addsub15_arbiter.md
Name: addsub15_arbiter

Overview:
- Shares one external 15-bit carry-ripple adder/subtractor datapath between two requesters.
- Arbitrates round-robin, drives operands and the subtract control (C0) to the datapath, waits a fixed ripple-settle time, then captures the sum and overflow.
- Returns the captured result to the granted requester over a valid/ready handshake.
- Sits between the ALU-side requesters and the combinational adder/subtractor schematic.

Parameters:
- WIDTH, 15, datapath operand/result width (two's complement).
- SETTLE_CYC, 4, clock cycles operands are held before capturing dp_s/dp_v. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accepted (one-hot or zero).
- req_a  in  2*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B; same packing as req_a.
- req_sub  in  2  1 = A-B, 0 = A+B.
- rsp_valid  out  2  result valid to requester i (one-hot or zero).
- rsp_ready  in  2  requester i accepts the result.
- rsp_s  out  WIDTH  result value, shared bus, meaningful while any rsp_valid is high.
- rsp_v  out  1  signed overflow flag accompanying rsp_s.
- dp_a  out  WIDTH  operand A to the datapath.
- dp_b  out  WIDTH  operand B to the datapath.
- dp_c0  out  1  datapath C0 / subtract control.
- dp_s  in  WIDTH  datapath sum output.
- dp_v  in  1  datapath overflow output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state = IDLE; grant pointer = requester 0 has priority.
  - All outputs are 0 at reset: req_ready, rsp_valid, rsp_s, rsp_v, dp_a, dp_b, dp_c0, busy.
- IDLE:
  - If any req_valid is set, pick a winner: the pointer requester if it is valid, else the other one.
  - In that same cycle, assert req_ready[winner] combinationally.
  - On the clock edge, latch the winner's operands into dp_a/dp_b/dp_c0 registers, load settle counter = SETTLE_CYC-1, go to EXEC.
  - The pointer flips to the non-winner on every grant.
- EXEC:
  - dp_a/dp_b/dp_c0 are held stable.
  - Counter decrements each cycle.
  - When the counter reaches 0, capture dp_s into rsp_s and dp_v into rsp_v, then go to RESP.
  - Grant-to-capture latency is exactly SETTLE_CYC cycles after the accept edge.
- RESP:
  - rsp_valid[granted] is high and rsp_s/rsp_v are stable until rsp_ready[granted] is high on a clock edge.
  - At that edge, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- No new request is accepted in EXEC or RESP; req_ready = 0 there.
  - Back-to-back operation: IDLE lasts at least one cycle between operations.
  - Minimum throughput is one op per SETTLE_CYC+2 cycles.
- Simultaneous valid requests: the pointer decides. A requester that is continuously valid is served within 2 grants.
- A requester dropping req_valid while not granted is legal and has no effect.
- dp_a/dp_b/dp_c0 retain the last operands in IDLE; they are not cleared.
- Asynchronous reset mid-EXEC or mid-RESP:
  - The operation is abandoned and no rsp_valid is emitted.
  - The pointer returns to 0.
- Overflow is taken from dp_v as-is: V = carry into MSB XOR carry out of MSB. The block does not recompute it.

Optional Feature:
- Macro: ADDSUB15_ARB_SAT_EN.
- Defined: on capture with dp_v = 1, rsp_s saturates.
  - If the true result is positive overflow (sign of dp_s = 1), rsp_s = 0x3FFF.
  - If the true result is negative overflow (sign of dp_s = 0), rsp_s = 0x4000.
  - rsp_v still reports 1.
- Undefined: rsp_s = dp_s (wrap-around); rsp_v = dp_v.

Decomposition:
- Package addsub15_pkg:
  - WIDTH constant.
  - State enum {IDLE, EXEC, RESP}.
  - Saturation constants SAT_MAX = 15'h3FFF and SAT_MIN = 15'h4000.
- One sub-module: rr_arb2, a 2-input round-robin picker with a pointer register, grant one-hot and update strobe.
  - Operand muxing and the FSM stay in the top.

Test Plan:
- Single subtract: req0 with A = 0x4000, B = 0x2004, sub = 1, external model dp_s = A-B.
  - Expected: dp_c0 = 1; rsp_s = 0x1FFC, rsp_v = 1 after SETTLE_CYC cycles.
  - With ADDSUB15_ARB_SAT_EN: rsp_s = 0x4000.
- Add without overflow: req1 with A = 0x0005, B = 0x0003, sub = 0 -> rsp_valid = 2'b10, rsp_s = 0x0008, rsp_v = 0; latency SETTLE_CYC from the accept edge.
- Contention: both valid from reset -> grant order req0, req1, req0 …; req_ready is never 2'b11.
- Backpressure: hold rsp_ready = 0 for 10 cycles in RESP -> rsp_s, rsp_v and rsp_valid stay stable; req_ready = 0 throughout.
- Reset mid-EXEC: assert rst_n = 0 for 1 cycle -> all outputs 0 immediately, no rsp_valid afterward, next grant goes to req0.
- Operand stability: change req_a during EXEC -> dp_a unchanged until the next grant.
